// File: rtl/seq_div_8bit_if.sv
// Operand/result bundle for the sequential restoring divider.
// Handshake: i_start is sampled only while o_busy is low; results are valid in the
// single cycle o_done is high and hold until the next o_done.
interface seq_div_8bit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_value_a;
  logic [DATA_WIDTH-1:0] i_value_b;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_value_quot;
  logic [DATA_WIDTH-1:0] o_value_rem;
  logic                  o_div_by_zero;
  logic [1:0]            o_state;

  modport master (
    output i_start, i_value_a, i_value_b,
    input  o_busy, o_done, o_value_quot, o_value_rem, o_div_by_zero, o_state
  );

  modport slave (
    input  i_start, i_value_a, i_value_b,
    output o_busy, o_done, o_value_quot, o_value_rem, o_div_by_zero, o_state
  );
endinterface

// File: rtl/seq_div_8bit.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Results and the done pulse are registered on the edge that leaves DONE.
module seq_div_8bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_div_8bit_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_quot_q, out_quot_d;
  logic [DATA_WIDTH-1:0] out_rem_q, out_rem_d;
  logic                  out_dbz_q, out_dbz_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;

  // Since rem < b, the top bit of the (W+1)-bit difference is exactly the borrow.
  always_comb begin
    trial = {rem_q, sh_q[DATA_WIDTH-1]};
    diff  = trial - {1'b0, b_q};
    fits  = ~diff[DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = (bus.i_value_b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sh_d       = sh_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_dbz_d  = out_dbz_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          a_d    = bus.i_value_a;
          b_d    = bus.i_value_b;
          sh_d   = bus.i_value_a;
          rem_d  = '0;
          quot_d = '0;
          cnt_d  = '0;
        end
      end
      CALC: begin
        sh_d   = sh_q << 1;
        rem_d  = fits ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        quot_d = {quot_q[DATA_WIDTH-2:0], fits};
        cnt_d  = cnt_q + CW'(1);
      end
      DONE: begin
        done_d = 1'b1;
        if (b_q == '0) begin
          out_quot_d = '1;
          out_rem_d  = a_q;
          out_dbz_d  = 1'b1;
        end else begin
          out_quot_d = quot_q;
          out_rem_d  = rem_q;
          out_dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_dbz_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sh_q       <= sh_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_dbz_q  <= out_dbz_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_value_quot  = out_quot_q;
  assign bus.o_value_rem   = out_rem_q;
  assign bus.o_div_by_zero = out_dbz_q;
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_seq_div_8bit.sv
// Directed and random-operand bench for seq_div_8bit; inputs change and outputs are
// sampled on the falling clock edge.
module tb_seq_div_8bit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_div_8bit_if #(.DATA_WIDTH(8)) bus ();

  seq_div_8bit #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_value_a = a;
    bus.i_value_b = b;
    @(negedge clk);
    bus.i_start   = 1'b0;
  endtask

  // Counts falling edges until o_done; held drops if results move before o_done.
  task automatic wait_done(input int budget, output int lat, output bit held);
    logic [7:0] q0, r0;
    logic       z0;
    q0   = bus.o_value_quot;
    r0   = bus.o_value_rem;
    z0   = bus.o_div_by_zero;
    lat  = 0;
    held = 1'b1;
    while (bus.o_done !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
      if (bus.o_done !== 1'b1 &&
          (bus.o_value_quot !== q0 || bus.o_value_rem !== r0 || bus.o_div_by_zero !== z0))
        held = 1'b0;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez,
                        input int elat);
    int lat;
    bit held;
    drive_start(a, b);
    check({tag, "_busy"}, bus.o_busy, 1);
    wait_done(20, lat, held);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quot"}, bus.o_value_quot, eq);
    check({tag, "_rem"}, bus.o_value_rem, er);
    check({tag, "_dbz"}, bus.o_div_by_zero, ez);
    check({tag, "_hold"}, held, 1);
    @(negedge clk);
    check({tag, "_pulse"}, bus.o_done, 0);
  endtask

  logic [7:0] ca, cb;
  int lat_v, nd;
  bit held_v;

  initial begin
    bus.i_start   = 1'b0;
    bus.i_value_a = '0;
    bus.i_value_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_quot", bus.o_value_quot, 0);
    check("rst_rem", bus.o_value_rem, 0);
    check("rst_dbz", bus.o_div_by_zero, 0);
    check("rst_state", bus.o_state, 0);
    reset_n = 1'b1;

    // Basic and extremes
    run_op("basic",   8'd20,  8'd10,  8'd2,   8'd0, 1'b0, 9);
    run_op("a255b1",  8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9);
    run_op("a7b20",   8'd7,   8'd20,  8'd0,   8'd7, 1'b0, 9);
    run_op("a255b255",8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9);
    run_op("a200b13", 8'd200, 8'd13,  8'd15,  8'd5, 1'b0, 9);

    // Divide by zero, then a normal op clears the flag
    run_op("dbz",     8'd20,  8'd0,   8'hFF,  8'd20, 1'b1, 1);
    run_op("after_dbz", 8'd9, 8'd2,   8'd4,   8'd1,  1'b0, 9);

    // Start pulse during CALC cycle 3 is ignored
    drive_start(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    check("busy_ign_state", bus.o_state, 1);
    bus.i_start   = 1'b1;
    bus.i_value_a = 8'd1;
    bus.i_value_b = 8'd1;
    @(negedge clk);
    bus.i_start   = 1'b0;
    wait_done(20, lat_v, held_v);
    check("busy_ign_latency", lat_v, 6);
    check("busy_ign_quot", bus.o_value_quot, 14);
    check("busy_ign_rem", bus.o_value_rem, 2);
    check("busy_ign_hold", held_v, 1);
    count_dones(15, nd);
    check("busy_ign_single_done", nd, 0);
    check("busy_ign_idle", bus.o_busy, 0);

    // Reset during CALC cycle 4
    drive_start(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_quot", bus.o_value_quot, 0);
    check("midrst_rem", bus.o_value_rem, 0);
    check("midrst_dbz", bus.o_div_by_zero, 0);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_done", bus.o_done, 0);
    check("midrst_state", bus.o_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_dones(12, nd);
    check("midrst_no_done", nd, 0);

    // Start accepted on the first rising edge after reset release
    reset_n = 1'b0;
    @(negedge clk);
    reset_n       = 1'b1;
    bus.i_start   = 1'b1;
    bus.i_value_a = 8'd50;
    bus.i_value_b = 8'd5;
    @(negedge clk);
    bus.i_start   = 1'b0;
    check("postrst_busy", bus.o_busy, 1);
    wait_done(20, lat_v, held_v);
    check("postrst_latency", lat_v, 9);
    check("postrst_quot", bus.o_value_quot, 10);
    check("postrst_rem", bus.o_value_rem, 0);
    @(negedge clk);

    // Back-to-back random operations with i_start held high
    ca = 8'($urandom_range(0, 255));
    cb = 8'($urandom_range(1, 255));
    bus.i_start   = 1'b1;
    bus.i_value_a = ca;
    bus.i_value_b = cb;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      wait_done(20, lat_v, held_v);
      check("rnd_latency", lat_v, 9);
      check("rnd_quot", bus.o_value_quot, 32'(ca / cb));
      check("rnd_rem", bus.o_value_rem, 32'(ca % cb));
      check("rnd_identity", 32'(int'(bus.o_value_quot) * int'(cb) + int'(bus.o_value_rem)), 32'(ca));
      check("rnd_rem_lt_b", 32'(bus.o_value_rem < cb), 1);
      check("rnd_dbz", bus.o_div_by_zero, 0);
      if (i == 999) begin
        bus.i_start = 1'b0;
      end else begin
        ca = 8'($urandom_range(0, 255));
        cb = 8'($urandom_range(1, 255));
        bus.i_value_a = ca;
        bus.i_value_b = cb;
      end
      @(negedge clk);
      check("rnd_pulse", bus.o_done, 0);
    end
    count_dones(12, nd);
    check("rnd_stop", nd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
